// File: rtl/caf_sweep_ctrl.sv
// rtl/caf_sweep_ctrl.sv - Doppler-bin sweep sequencer driving one caf_slice
//
// Purpose: steps one correlator slice across 2*num_bins-1 Doppler bins
// (k=0..num_bins-1 positive, then k=1..num_bins-1 negative). For each bin it
// programs freq_step/neg_shift, gates exactly `length` sample handshakes into
// the slice, waits for the peak result and keeps the best (max, lag, bin, sign).
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start, freq_base, freq_inc  sweep request and frequency plan (latched)
//   busy, done                  sweep in progress / one-cycle completion pulse
//   src_tvalid, src_tready      sample source handshake
//   slice_freq_step/neg_shift   per-bin slice programming
//   slice_m_tvalid/s_tready     sample path into the slice
//   slice_res_tvalid/tready,
//   slice_out_max, slice_index  peak result from the slice
//   best_max/index/bin/neg      winning result of the last sweep
//   timeout_err                 sticky result-watchdog flag
//
// Optional feature: define CAF_SWEEP_TIMEOUT_EN to enable the result watchdog
// (bins whose result never arrives within timeout_cycles are skipped).

module caf_sweep_ctrl #(
  parameter int phase_bits          = 10,
  parameter int length              = 5,
  parameter int length_counter_bits = 3,
  parameter int out_max_bits        = 5,
  parameter int num_bins            = 4,
  parameter int bin_bits            = 3,
  parameter int timeout_cycles      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [phase_bits-1:0]          freq_base,
  input  logic [phase_bits-1:0]          freq_inc,
  output logic                           busy,
  output logic                           done,
  input  logic                           src_tvalid,
  output logic                           src_tready,
  output logic [phase_bits-1:0]          slice_freq_step,
  output logic                           slice_neg_shift,
  output logic                           slice_m_tvalid,
  input  logic                           slice_s_tready,
  input  logic                           slice_res_tvalid,
  input  logic [out_max_bits-1:0]        slice_out_max,
  input  logic [length_counter_bits-1:0] slice_index,
  output logic                           slice_res_tready,
  output logic [out_max_bits-1:0]        best_max,
  output logic [length_counter_bits-1:0] best_index,
  output logic [bin_bits-1:0]            best_bin,
  output logic                           best_neg,
  output logic                           timeout_err
);

  localparam int CNT_W = $clog2(length + 1);
  localparam logic [CNT_W-1:0]    LAST_HS = CNT_W'(length - 1);
  localparam logic [bin_bits-1:0] LAST_K  = bin_bits'(num_bins - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FEED, S_WAIT, S_CMP, S_NEXT, S_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [phase_bits-1:0]          base_q, base_d;
  logic [phase_bits-1:0]          inc_q, inc_d;
  logic [phase_bits-1:0]          cur_freq_q, cur_freq_d;
  logic [bin_bits-1:0]            k_q, k_d;
  logic                           neg_q, neg_d;
  logic [phase_bits-1:0]          freq_out_q, freq_out_d;
  logic                           neg_out_q, neg_out_d;
  logic [CNT_W-1:0]               hs_cnt_q, hs_cnt_d;
  logic [out_max_bits-1:0]        res_max_q, res_max_d;
  logic [length_counter_bits-1:0] res_idx_q, res_idx_d;
  logic [out_max_bits-1:0]        best_max_q, best_max_d;
  logic [length_counter_bits-1:0] best_idx_q, best_idx_d;
  logic [bin_bits-1:0]            best_bin_q, best_bin_d;
  logic                           best_neg_q, best_neg_d;
  logic                           best_valid_q, best_valid_d;
  logic                           last_bin;

`ifdef CAF_SWEEP_TIMEOUT_EN
  localparam int TO_W = $clog2(timeout_cycles + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(timeout_cycles - 1);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // Zero bin is visited only once, so the sweep ends on the last negative bin
  // (or on k=0 when there is only the zero bin).
  assign last_bin = (k_q == LAST_K) && (neg_q || (num_bins == 1));

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    inc_d        = inc_q;
    cur_freq_d   = cur_freq_q;
    k_d          = k_q;
    neg_d        = neg_q;
    freq_out_d   = freq_out_q;
    neg_out_d    = neg_out_q;
    hs_cnt_d     = hs_cnt_q;
    res_max_d    = res_max_q;
    res_idx_d    = res_idx_q;
    best_max_d   = best_max_q;
    best_idx_d   = best_idx_q;
    best_bin_d   = best_bin_q;
    best_neg_d   = best_neg_q;
    best_valid_d = best_valid_q;
`ifdef CAF_SWEEP_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d       = freq_base;
          inc_d        = freq_inc;
          cur_freq_d   = freq_base;
          k_d          = '0;
          neg_d        = 1'b0;
          best_max_d   = '0;
          best_idx_d   = '0;
          best_bin_d   = '0;
          best_neg_d   = 1'b0;
          best_valid_d = 1'b0;
`ifdef CAF_SWEEP_TIMEOUT_EN
          timeout_d    = 1'b0;
`endif
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        freq_out_d = cur_freq_q;
        neg_out_d  = neg_q;
        hs_cnt_d   = '0;
        state_d    = S_FEED;
      end
      S_FEED: begin
        if (src_tvalid && slice_s_tready) begin
          if (hs_cnt_q == LAST_HS) begin
`ifdef CAF_SWEEP_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
            state_d = S_WAIT;
          end else begin
            hs_cnt_d = hs_cnt_q + 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (slice_res_tvalid) begin
          res_max_d = slice_out_max;
          res_idx_d = slice_index;
          state_d   = S_CMP;
        end
`ifdef CAF_SWEEP_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          // Result never came: flag it and skip this bin without comparing.
          timeout_d = 1'b1;
          state_d   = S_NEXT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      S_CMP: begin
        // Strictly greater: ties keep the earlier bin.
        if (!best_valid_q || (res_max_q > best_max_q)) begin
          best_max_d = res_max_q;
          best_idx_d = res_idx_q;
          best_bin_d = k_q;
          best_neg_d = neg_q;
        end
        best_valid_d = 1'b1;
        state_d      = S_NEXT;
      end
      S_NEXT: begin
        if (last_bin) begin
          state_d = S_DONE;
        end else begin
          if (!neg_q && (k_q == LAST_K)) begin
            // Turn around to the negative side, starting at k=1.
            k_d        = bin_bits'(1);
            neg_d      = 1'b1;
            cur_freq_d = base_q + inc_q;
          end else begin
            k_d        = k_q + 1'b1;
            cur_freq_d = cur_freq_q + inc_q;
          end
          state_d = S_LOAD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      inc_q        <= '0;
      cur_freq_q   <= '0;
      k_q          <= '0;
      neg_q        <= 1'b0;
      freq_out_q   <= '0;
      neg_out_q    <= 1'b0;
      hs_cnt_q     <= '0;
      res_max_q    <= '0;
      res_idx_q    <= '0;
      best_max_q   <= '0;
      best_idx_q   <= '0;
      best_bin_q   <= '0;
      best_neg_q   <= 1'b0;
      best_valid_q <= 1'b0;
`ifdef CAF_SWEEP_TIMEOUT_EN
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      inc_q        <= inc_d;
      cur_freq_q   <= cur_freq_d;
      k_q          <= k_d;
      neg_q        <= neg_d;
      freq_out_q   <= freq_out_d;
      neg_out_q    <= neg_out_d;
      hs_cnt_q     <= hs_cnt_d;
      res_max_q    <= res_max_d;
      res_idx_q    <= res_idx_d;
      best_max_q   <= best_max_d;
      best_idx_q   <= best_idx_d;
      best_bin_q   <= best_bin_d;
      best_neg_q   <= best_neg_d;
      best_valid_q <= best_valid_d;
`ifdef CAF_SWEEP_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign src_tready       = (state_q == S_FEED) && slice_s_tready;
  assign slice_m_tvalid   = (state_q == S_FEED) && src_tvalid;
  assign slice_res_tready = (state_q == S_WAIT);
  assign slice_freq_step  = freq_out_q;
  assign slice_neg_shift  = neg_out_q;
  assign best_max         = best_max_q;
  assign best_index       = best_idx_q;
  assign best_bin         = best_bin_q;
  assign best_neg         = best_neg_q;

`ifdef CAF_SWEEP_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  // Watchdog compiled out; timeout_cycles is kept so both builds share one interface.
  assign timeout_err = (timeout_cycles < 0);
`endif

endmodule

// File: tb/tb_caf_sweep_ctrl.sv
// tb/tb_caf_sweep_ctrl.sv - self-checking bench for caf_sweep_ctrl
module tb_caf_sweep_ctrl;

  localparam int NB    = 4;
  localparam int NBINS = 2 * NB - 1;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [9:0] freq_base, freq_inc;
  logic       busy, done;
  logic       src_tvalid, src_tready;
  logic [9:0] slice_freq_step;
  logic       slice_neg_shift, slice_m_tvalid, slice_s_tready;
  logic       slice_res_tvalid, slice_res_tready;
  logic [4:0] slice_out_max;
  logic [2:0] slice_index;
  logic [4:0] best_max;
  logic [2:0] best_index, best_bin;
  logic       best_neg, timeout_err;

  always #5 clk = ~clk;

  caf_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .freq_base(freq_base), .freq_inc(freq_inc),
    .busy(busy), .done(done), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .slice_freq_step(slice_freq_step), .slice_neg_shift(slice_neg_shift),
    .slice_m_tvalid(slice_m_tvalid), .slice_s_tready(slice_s_tready),
    .slice_res_tvalid(slice_res_tvalid), .slice_out_max(slice_out_max),
    .slice_index(slice_index), .slice_res_tready(slice_res_tready),
    .best_max(best_max), .best_index(best_index), .best_bin(best_bin),
    .best_neg(best_neg), .timeout_err(timeout_err)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Slice / source model state
  int m_max[16], m_idx[16];
  int hs_cnt[16], freq_seen[16], neg_seen[16];
  int bin_no, fed, pending, lat, wcnt, prev_rr, wait_seen;
  int unstable, extra_hs, viol, done_cnt;
  int withhold = -1;
  int p_valid = 70, p_ready = 70;

  task automatic model_clear();
    for (int b = 0; b < 16; b++) begin
      hs_cnt[b] = 0; freq_seen[b] = -1; neg_seen[b] = -1;
    end
    bin_no = 0; fed = 0; pending = 0; lat = 0; wcnt = 0; prev_rr = 0; wait_seen = 0;
    unstable = 0; extra_hs = 0; viol = 0; done_cnt = 0;
  endtask

  always @(negedge clk) begin
    int bi;
    int hs;
    bi = (bin_no < 15) ? bin_no : 15;
    src_tvalid       = ($urandom_range(0, 99) < p_valid);
    slice_s_tready   = ($urandom_range(0, 99) < p_ready);
    slice_res_tvalid = pending && (lat == 0) && (bin_no != withhold);
    slice_out_max    = 5'(m_max[bi]);
    slice_index      = 3'(m_idx[bi]);
    #1;
    hs = slice_m_tvalid && slice_s_tready;
    if ((src_tvalid && src_tready) != hs) viol++;
    if (slice_m_tvalid && !src_tvalid) viol++;
    if (!busy && (slice_m_tvalid || src_tready || slice_res_tready)) viol++;
    if (hs) begin
      if (pending) extra_hs++;
      else begin
        if (freq_seen[bi] < 0) begin
          freq_seen[bi] = slice_freq_step; neg_seen[bi] = slice_neg_shift;
        end else if (freq_seen[bi] != slice_freq_step || neg_seen[bi] != slice_neg_shift)
          unstable++;
        hs_cnt[bi]++;
        fed++;
        if (fed == 5) begin pending = 1; lat = $urandom_range(0, 3); wcnt = 0; end
      end
    end else if (pending && lat > 0) lat--;
    if (slice_res_tvalid && slice_res_tready) begin
      bin_no++; fed = 0; pending = 0;
    end else if (pending && bin_no == withhold) begin
      if (slice_res_tready) wcnt++;
      else if (prev_rr != 0) begin
        wait_seen = wcnt; bin_no++; fed = 0; pending = 0;
      end
    end
    prev_rr = slice_res_tready;
    if (done) done_cnt++;
  end

  typedef struct packed {
    logic [9:0]      base;
    logic [9:0]      inc;
    logic [6:0][4:0] mx;
    logic [6:0][2:0] ix;
    logic [4:0]      e_max;
    logic [2:0]      e_idx;
    logic [2:0]      e_bin;
    logic            e_neg;
  } vec_t;

  function automatic int k_of(input int b);
    return (b < NB) ? b : b - NB + 1;
  endfunction

  function automatic int exp_freq(input int base, input int inc, input int b);
    return (base + k_of(b) * inc) % 1024;
  endfunction

  // Reference: global maximum over compared bins, first bin in sweep order wins.
  function automatic vec_t mkv(input int base, input int inc, input int mx[7],
                               input int ix[7], input int skip);
    vec_t v;
    int   top = -1;
    int   win = 0;
    v = '0;
    v.base = 10'(base); v.inc = 10'(inc);
    for (int b = 0; b < NBINS; b++) begin
      v.mx[b] = 5'(mx[b]); v.ix[b] = 3'(ix[b]);
      if (b != skip && mx[b] > top) top = mx[b];
    end
    for (int b = NBINS - 1; b >= 0; b--)
      if (b != skip && mx[b] == top) win = b;
    v.e_max = 5'(top); v.e_idx = 3'(ix[win]);
    v.e_bin = 3'(k_of(win)); v.e_neg = (win >= NB);
    return v;
  endfunction

  task automatic load_model(input vec_t v, input int skip);
    @(negedge clk); #2;
    model_clear();
    for (int b = 0; b < 16; b++) begin
      m_max[b] = (b < NBINS) ? int'(v.mx[b]) : 0;
      m_idx[b] = (b < NBINS) ? int'(v.ix[b]) : 0;
    end
    withhold = skip;
    p_valid = $urandom_range(30, 100);
    p_ready = $urandom_range(30, 100);
  endtask

  task automatic run_sweep(input string tag, input vec_t v, input int skip);
    int n;
    load_model(v, skip);
    freq_base = v.base; freq_inc = v.inc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    freq_base = 10'($urandom); freq_inc = 10'($urandom);
    check({tag, "_busy"}, busy, 1);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_done_in_time"}, (n < 3000), 1);
    repeat (3) @(negedge clk);
    #2;
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_bins"}, bin_no, NBINS);
    for (int b = 0; b < NBINS; b++) begin
      check($sformatf("%s_hs_b%0d", tag, b), hs_cnt[b], 5);
      check($sformatf("%s_freq_b%0d", tag, b), freq_seen[b], exp_freq(v.base, v.inc, b));
      check($sformatf("%s_neg_b%0d", tag, b), neg_seen[b], (b >= NB));
    end
    check({tag, "_extra_hs"}, extra_hs, 0);
    check({tag, "_unstable"}, unstable, 0);
    check({tag, "_protocol"}, viol, 0);
    check({tag, "_best_max"}, best_max, v.e_max);
    check({tag, "_best_index"}, best_index, v.e_idx);
    check({tag, "_best_bin"}, best_bin, v.e_bin);
    check({tag, "_best_neg"}, best_neg, v.e_neg);
    check({tag, "_timeout_err"}, timeout_err, (skip >= 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_src_tready"}, src_tready, 0);
    check({tag, "_m_tvalid"}, slice_m_tvalid, 0);
    check({tag, "_res_tready"}, slice_res_tready, 0);
    check({tag, "_freq_step"}, slice_freq_step, 0);
    check({tag, "_neg_shift"}, slice_neg_shift, 0);
    check({tag, "_best_max"}, best_max, 0);
    check({tag, "_best_index"}, best_index, 0);
    check({tag, "_best_bin"}, best_bin, 0);
    check({tag, "_best_neg"}, best_neg, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  vec_t vecs[8];
  int   a_mx[7], a_ix[7];
  int   n_wait;

  initial begin
    rst = 1'b1; start = 1'b0; freq_base = '0; freq_inc = '0;
    model_clear();
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");
    rst = 1'b0;

    a_mx = '{3, 9, 4, 9, 1, 2, 7}; a_ix = '{1, 2, 3, 4, 0, 1, 2};
    vecs[0] = mkv(0, 8, a_mx, a_ix, -1);
    vecs[0].e_max = 5'd9; vecs[0].e_idx = 3'd2; vecs[0].e_bin = 3'd1; vecs[0].e_neg = 1'b0;
    a_mx = '{5, 5, 5, 5, 5, 5, 5}; a_ix = '{3, 1, 2, 4, 0, 1, 2};
    vecs[1] = mkv(1020, 8, a_mx, a_ix, -1);
    vecs[1].e_max = 5'd5; vecs[1].e_idx = 3'd3; vecs[1].e_bin = 3'd0; vecs[1].e_neg = 1'b0;
    a_mx = '{1, 2, 3, 4, 5, 30, 6}; a_ix = '{0, 0, 0, 0, 0, 4, 0};
    vecs[2] = mkv(100, 1000, a_mx, a_ix, -1);
    vecs[2].e_max = 5'd30; vecs[2].e_idx = 3'd4; vecs[2].e_bin = 3'd2; vecs[2].e_neg = 1'b1;
    a_mx = '{0, 0, 0, 0, 0, 0, 0}; a_ix = '{4, 1, 2, 3, 1, 2, 3};
    vecs[3] = mkv(7, 3, a_mx, a_ix, -1);
    vecs[3].e_max = 5'd0; vecs[3].e_idx = 3'd4; vecs[3].e_bin = 3'd0; vecs[3].e_neg = 1'b0;
    for (int i = 4; i < 8; i++) begin
      for (int b = 0; b < NBINS; b++) begin
        a_mx[b] = $urandom_range(0, 31); a_ix[b] = $urandom_range(0, 4);
      end
      vecs[i] = mkv($urandom_range(0, 1023), $urandom_range(0, 1023), a_mx, a_ix, -1);
    end

    for (int i = 0; i < 8; i++) run_sweep($sformatf("v%0d", i), vecs[i], -1);

    // Reset during FEED of bin 3 aborts without a done pulse
    load_model(vecs[5], -1);
    freq_base = vecs[5].base; freq_inc = vecs[5].inc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_wait = 0;
    while (!(bin_no == 3 && fed >= 1) && n_wait < 3000) begin @(negedge clk); n_wait++; end
    check("rst_reach_bin3", (n_wait < 3000), 1);
    rst = 1'b1;
    @(negedge clk); #2;
    check_reset_outputs("midrst");
    model_clear();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle", busy, 0);
    run_sweep("after_rst", vecs[6], -1);

`ifdef CAF_SWEEP_TIMEOUT_EN
    a_mx = '{3, 4, 31, 5, 2, 1, 0}; a_ix = '{1, 1, 4, 2, 3, 0, 1};
    run_sweep("tmo", mkv(16, 40, a_mx, a_ix, 2), 2);
    check("tmo_wait_cycles", wait_seen, 64);
    run_sweep("tmo_clear", vecs[0], -1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/caf_sweep_ctrl.md
Name: caf_sweep_ctrl

Overview:
Sequencer that drives one caf_slice across a bank of Doppler bins to build a full cross-ambiguity search from a single correlator slice. For each bin it programs freq_step/neg_shift, gates exactly `length` sample handshakes from the sample source into the slice, and waits for the slice's peak result. It tracks the best peak magnitude, lag index and bin across the sweep, then reports a single winner.

Parameters:
phase_bits, 10, width of freq_step / freq_base / freq_inc
length, 5, samples per correlation (must match slice)
length_counter_bits, 3, width of slice lag index
out_max_bits, 5, width of slice peak magnitude
num_bins, 4, positive bins per sweep (k=0..num_bins-1); total bins = 2*num_bins-1
bin_bits, 3, width of bin counter (≥ clog2(num_bins))
timeout_cycles, 64, result watchdog limit (used only with CAF_SWEEP_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin sweep (sampled in IDLE only)
freq_base  in  phase_bits  freq_step of bin 0 (latched at start)
freq_inc  in  phase_bits  per-bin freq_step increment (latched at start)
busy  out  1  high from start acceptance through DONE
done  out  1  one-cycle pulse when sweep completes
src_tvalid  in  1  sample source valid
src_tready  out  1  sample source ready
slice_freq_step  out  phase_bits  to slice freq_step
slice_neg_shift  out  1  to slice neg_shift
slice_m_tvalid  out  1  to slice m_axis_tvalid
slice_s_tready  in  1  from slice s_axis_tready
slice_res_tvalid  in  1  from slice s_axis_tvalid
slice_out_max  in  out_max_bits  from slice out_max
slice_index  in  length_counter_bits  from slice index
slice_res_tready  out  1  to slice m_axis_tready
best_max  out  out_max_bits  winning peak magnitude
best_index  out  length_counter_bits  winning lag
best_bin  out  bin_bits  winning bin k
best_neg  out  1  winning bin sign
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset: state IDLE; busy=0, done=0, src_tready=0, slice_m_tvalid=0, slice_res_tready=0, slice_freq_step=0, slice_neg_shift=0, best_*=0, timeout_err=0. Reset mid-sweep aborts immediately; no done pulse.
- Bin order: k=0..num_bins-1 with neg=0, then k=1..num_bins-1 with neg=1 (zero bin not repeated). freq_step = freq_base + k*freq_inc, computed by accumulation, modulo 2^phase_bits (wrap, no saturation).
- IDLE: start=1 -> latch freq_base/freq_inc, k=0, neg=0, best_*=0, clear best_valid -> LOAD; busy=1 next cycle. start while busy ignored.
- LOAD (1 cycle): register slice_freq_step/slice_neg_shift; stable until bin ends -> FEED.
- FEED: src_tready = slice_s_tready; slice_m_tvalid = src_tvalid; handshake = src_tvalid & slice_s_tready; count handshakes; after the length-th -> WAIT; src_tready=0 outside FEED.
- WAIT: slice_res_tready=1; on slice_res_tvalid -> CMP with result captured.
- CMP (1 cycle): if !best_valid or slice_out_max > best_max (strictly greater, unsigned), update best_max/index/bin/neg; ties keep earlier bin. -> NEXT.
- NEXT: advance bin per order; last bin (k=num_bins-1, neg=1; or k=0 when num_bins=1) -> DONE, else LOAD.
- DONE (1 cycle): done=1, busy=0 next cycle -> IDLE. best_* hold until next start.
- Latency per bin: 1 (LOAD) + length handshakes + slice latency + 2 (CMP, NEXT).

Optional Feature:
Macro CAF_SWEEP_TIMEOUT_EN. Defined: cycle counter in WAIT; reaching timeout_cycles without slice_res_tvalid sets timeout_err (sticky until rst or next start), bin skipped (no compare) -> NEXT. Undefined: WAIT waits indefinitely; timeout_err tied 0.

Test Plan:
- num_bins=4, freq_base=0, freq_inc=8: slice_freq_step sequence 0,8,16,24 (neg=0), 8,16,24 (neg=1); 7 bins, exactly 5 src handshakes each, one done pulse.
- Model returns out_max 3,9,4,9,1,2,7: best_max=9, best_bin=1, best_neg=0 (tie keeps first).
- freq_base=1020, freq_inc=8: bins 1020, 4, 12, 20 (wrap mod 1024).
- src_tvalid/slice_s_tready toggled randomly: exactly 5 handshakes per bin, no slice_m_tvalid outside FEED.
- rst asserted during FEED of bin 3: all outputs reset next cycle, no done; new start restarts at bin 0.
- CAF_SWEEP_TIMEOUT_EN, slice withholds result on bin 2: timeout_err=1 after 64 WAIT cycles, sweep completes, bin 2 excluded from best.
